// File: rtl/flash_mp_pkg.sv
// Shared types for the flash data-region request arbiter: operations, region attributes and
// the per-region configuration record scanned by the arbiter.
package flash_mp_pkg;

  localparam int unsigned MpAddrW = 8;

  typedef enum logic [1:0] {
    OpRead    = 2'd0,
    OpProg    = 2'd1,
    OpErase   = 2'd2,
    OpIllegal = 2'd3
  } op_e;

  typedef struct packed {
    logic en;
    logic rd_en;
    logic prog_en;
    logic erase_en;
  } data_region_attr_t;

  typedef struct packed {
    logic               en;
    logic               rd_en;
    logic               prog_en;
    logic               erase_en;
    logic [MpAddrW-1:0] base;
    logic [MpAddrW:0]   size;
  } region_cfg_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StIssue,
    StResp
  } arb_state_e;

  function automatic logic op_allowed(data_region_attr_t attr, op_e op);
    logic op_bit;
    unique case (op)
      OpRead:  op_bit = attr.rd_en;
      OpProg:  op_bit = attr.prog_en;
      OpErase: op_bit = attr.erase_en;
      default: op_bit = 1'b0;
    endcase
    return attr.en && op_bit;
  endfunction

endpackage

// File: rtl/flash_mp_req_arb_if.sv
// Requester, completion and flash-side handshake signals of the data-region arbiter.
interface flash_mp_req_arb_if #(
  parameter int unsigned AddrW = 8
);

  logic             hw_req;
  logic [AddrW-1:0] hw_addr;
  logic [1:0]       hw_op;
  logic             sw_req;
  logic [AddrW-1:0] sw_addr;
  logic [1:0]       sw_op;
  logic             hw_gnt;
  logic             sw_gnt;
  logic             flash_req;
  logic [AddrW-1:0] flash_addr;
  logic [1:0]       flash_op;
  logic             flash_done;
  logic             done;
  logic             done_src;
  logic             deny;
  logic             busy;

  modport master (
    output hw_req, hw_addr, hw_op, sw_req, sw_addr, sw_op, flash_done,
    input  hw_gnt, sw_gnt, flash_req, flash_addr, flash_op, done, done_src, deny, busy
  );

  modport slave (
    input  hw_req, hw_addr, hw_op, sw_req, sw_addr, sw_op, flash_done,
    output hw_gnt, sw_gnt, flash_req, flash_addr, flash_op, done, done_src, deny, busy
  );

endinterface

// File: rtl/flash_mp_data_region_sel.sv
// Picks the governing attributes (matched region or default) and turns them into a permit
// decision, with the optional hardware-requester bypass.
module flash_mp_data_region_sel
  import flash_mp_pkg::*;
#(
  parameter bit HwDataAttr = 1'b1
) (
  input  logic              hit_i,
  input  data_region_attr_t hit_attr_i,
  input  data_region_attr_t default_attr_i,
  input  logic              src_hw_i,
  input  op_e               op_i,
  output logic              permit_o
);

  data_region_attr_t w_attr;

  always_comb begin
    w_attr = hit_i ? hit_attr_i : default_attr_i;
    // The illegal op encoding is refused even for a bypassing hw requester.
    if (op_i == OpIllegal) begin
      permit_o = 1'b0;
    end else if (src_hw_i && HwDataAttr) begin
      permit_o = 1'b1;
    end else begin
      permit_o = op_allowed(w_attr, op_i);
    end
  end

endmodule

// File: rtl/flash_mp_req_arb.sv
// Round-robin hw/sw arbiter that scans the region table one entry per cycle and then either
// issues the access to flash or reports a deny.
module flash_mp_req_arb
  import flash_mp_pkg::*;
#(
  parameter int unsigned NumRegions = 4,
  parameter int unsigned AddrW      = MpAddrW,
  parameter bit          HwDataAttr = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  flash_mp_req_arb_if.slave              bus_io,
  input  region_cfg_t [NumRegions-1:0]   region_cfg_i,
  input  data_region_attr_t              default_attr_i
);

  localparam int unsigned    IdxW    = (NumRegions > 1) ? $clog2(NumRegions) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRegions - 1);

  arb_state_e        r_state, w_state_next;
  logic              r_src;      // 1 = hw owns the current operation
  logic              r_rr_last;  // 1 = hw was granted last
  logic [AddrW-1:0]  r_addr;
  logic [1:0]        r_op;
  logic [IdxW-1:0]   r_idx;
  logic              r_hit;
  data_region_attr_t r_attr;
  logic              r_deny;

  region_cfg_t       w_cfg;
  data_region_attr_t w_cfg_attr;
  data_region_attr_t w_attr_final;
  logic [AddrW+1:0]  w_lo, w_hi, w_addr_x;
  logic              w_match, w_hit_final, w_permit, w_any_req, w_pick_hw;

  assign w_cfg      = region_cfg_i[r_idx];
  assign w_cfg_attr = '{en: w_cfg.en, rd_en: w_cfg.rd_en, prog_en: w_cfg.prog_en,
                        erase_en: w_cfg.erase_en};

  // Two spare bits keep base + size from wrapping.
  assign w_lo     = {2'b00, w_cfg.base};
  assign w_hi     = w_lo + {1'b0, w_cfg.size};
  assign w_addr_x = {2'b00, r_addr};
  assign w_match  = w_cfg.en && (w_addr_x >= w_lo) && (w_addr_x < w_hi);

  assign w_hit_final  = r_hit | w_match;
  assign w_attr_final = r_hit ? r_attr : w_cfg_attr;

  assign w_any_req = bus_io.hw_req | bus_io.sw_req;
  assign w_pick_hw = bus_io.hw_req && (!bus_io.sw_req || !r_rr_last);

  flash_mp_data_region_sel #(
    .HwDataAttr (HwDataAttr)
  ) u_region_sel (
    .hit_i          (w_hit_final),
    .hit_attr_i     (w_attr_final),
    .default_attr_i (default_attr_i),
    .src_hw_i       (r_src),
    .op_i           (op_e'(r_op)),
    .permit_o       (w_permit)
  );

  always_comb begin
    w_state_next      = r_state;
    bus_io.hw_gnt     = 1'b0;
    bus_io.sw_gnt     = 1'b0;
    bus_io.flash_req  = 1'b0;
    bus_io.flash_addr = '0;
    bus_io.flash_op   = '0;
    bus_io.done       = 1'b0;
    bus_io.done_src   = 1'b0;
    bus_io.deny       = 1'b0;
    bus_io.busy       = (r_state != StIdle);
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          bus_io.hw_gnt = w_pick_hw;
          bus_io.sw_gnt = !w_pick_hw;
          w_state_next  = StScan;
        end
      end
      StScan: begin
        if (r_idx == LastIdx) begin
          w_state_next = w_permit ? StIssue : StResp;
        end
      end
      StIssue: begin
        bus_io.flash_req  = 1'b1;
        bus_io.flash_addr = r_addr;
        bus_io.flash_op   = r_op;
        if (bus_io.flash_done) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        bus_io.done     = 1'b1;
        bus_io.done_src = r_src;
        bus_io.deny     = r_deny;
        w_state_next    = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_src     <= 1'b0;
      r_rr_last <= 1'b0;
      r_addr    <= '0;
      r_op      <= '0;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      r_attr    <= '0;
      r_deny    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_src  <= w_pick_hw;
            r_addr <= w_pick_hw ? bus_io.hw_addr : bus_io.sw_addr;
            r_op   <= w_pick_hw ? bus_io.hw_op : bus_io.sw_op;
            r_idx  <= '0;
            r_hit  <= 1'b0;
            r_deny <= 1'b0;
          end
        end
        StScan: begin
          r_idx <= r_idx + 1'b1;
          if (!r_hit && w_match) begin
            r_hit  <= 1'b1;
            r_attr <= w_cfg_attr;
          end
          if (r_idx == LastIdx) begin
            r_deny <= !w_permit;
          end
        end
        StResp:  r_rr_last <= r_src;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_mp_req_arb.sv
// Scoreboard bench: two arbiters (hw bypass on / off) see the same requests; a table-walk
// model predicts grant order and deny, monitors check grants, flash issue and completions.
module tb_flash_mp_req_arb;
  import flash_mp_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 8;

  typedef struct {
    bit hw;
    int addr;
    int op;
    bit deny;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  region_cfg_t [NR-1:0] cfg_v = '0;
  data_region_attr_t    dflt_v = '0;

  int n_checks = 0;
  int n_fail = 0;
  int txn_id = 0;
  int rst_cnt = 0;
  bit hold_flash = 1'b0;
  bit t_hw, t_sw;
  int t_ha, t_ho, t_sa, t_so;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // First enabled region containing addr governs; otherwise the default attributes.
  function automatic bit model_deny(bit hw, int addr, int op, bit bypass);
    data_region_attr_t a;
    bit found;
    a = dflt_v;
    found = 1'b0;
    if (op == 3) return 1'b1;
    if (hw && bypass) return 1'b0;
    for (int r = 0; r < NR; r++) begin
      int base;
      int lim;
      base = int'(cfg_v[r].base);
      lim  = base + int'(cfg_v[r].size);
      if (!found && cfg_v[r].en && addr >= base && addr < lim) begin
        found = 1'b1;
        a.en = cfg_v[r].en;
        a.rd_en = cfg_v[r].rd_en;
        a.prog_en = cfg_v[r].prog_en;
        a.erase_en = cfg_v[r].erase_en;
      end
    end
    case (op)
      0:       return !(a.en && a.rd_en);
      1:       return !(a.en && a.prog_en);
      default: return !(a.en && a.erase_en);
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit Bypass = (g == 0);
    flash_mp_req_arb_if #(.AddrW(AW)) u_if ();
    flash_mp_req_arb #(
      .NumRegions (NR),
      .AddrW      (AW),
      .HwDataAttr (Bypass)
    ) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .bus_io         (u_if.slave),
      .region_cfg_i   (cfg_v),
      .default_attr_i (dflt_v)
    );

    exp_t q[$];
    int agent_done = 0;

    initial begin : responder
      bit armed;
      int left;
      armed = 1'b0;
      left = 0;
      u_if.flash_done = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (u_if.flash_req && !armed && !hold_flash) begin
          armed = 1'b1;
          left = $urandom_range(0, 3);
        end
        if (armed) begin
          if (left == 0) begin
            u_if.flash_done = 1'b1;
            armed = 1'b0;
          end else begin
            left--;
            u_if.flash_done = 1'b0;
          end
        end else begin
          // Stray completions while flash is idle must be ignored.
          u_if.flash_done = !u_if.flash_req && ($urandom_range(0, 5) == 0);
        end
      end
    end

    initial begin : agent
      bit hreq, sreq, hg, sg, rr_hw;
      int seen, my_rst, budget;
      exp_t eh, es;
      seen = 0;
      my_rst = 0;
      rr_hw = 1'b0;
      u_if.hw_req = 1'b0;
      u_if.sw_req = 1'b0;
      u_if.hw_addr = '0;
      u_if.sw_addr = '0;
      u_if.hw_op = '0;
      u_if.sw_op = '0;
      forever begin
        wait (txn_id != seen);
        seen = txn_id;
        if (my_rst != rst_cnt) begin
          my_rst = rst_cnt;
          rr_hw = 1'b0;
        end
        eh = '{hw: 1'b1, addr: t_ha, op: t_ho, deny: model_deny(1'b1, t_ha, t_ho, Bypass)};
        es = '{hw: 1'b0, addr: t_sa, op: t_so, deny: model_deny(1'b0, t_sa, t_so, Bypass)};
        if (t_hw && t_sw) begin
          if (rr_hw) begin q.push_back(es); q.push_back(eh); end
          else begin q.push_back(eh); q.push_back(es); end
        end else if (t_hw) begin
          q.push_back(eh);
          rr_hw = 1'b1;
        end else if (t_sw) begin
          q.push_back(es);
          rr_hw = 1'b0;
        end
        u_if.hw_addr = AW'(t_ha);
        u_if.hw_op = 2'(t_ho);
        u_if.sw_addr = AW'(t_sa);
        u_if.sw_op = 2'(t_so);
        hreq = t_hw;
        sreq = t_sw;
        u_if.hw_req = hreq;
        u_if.sw_req = sreq;
        budget = 0;
        while ((hreq || sreq || u_if.busy) && budget < 200) begin
          @(negedge clk);
          budget++;
          hg = u_if.hw_gnt;
          sg = u_if.sw_gnt;
          @(posedge clk);
          #1;
          if (hg) begin hreq = 1'b0; u_if.hw_req = 1'b0; end
          if (sg) begin sreq = 1'b0; u_if.sw_req = 1'b0; end
        end
        if (budget >= 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL agent%0d_timeout: got no completion, required one within 200 cycles", g);
          hreq = 1'b0;
          sreq = 1'b0;
          u_if.hw_req = 1'b0;
          u_if.sw_req = 1'b0;
        end
        agent_done = seen;
      end
    end

    initial begin : monitor
      int cyc, done_at;
      bit in_txn, fseen;
      exp_t e;
      cyc = 0;
      done_at = -1;
      in_txn = 1'b0;
      fseen = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          q.delete();
          in_txn = 1'b0;
        end else begin
          if (in_txn) cyc++;
          if (u_if.flash_req) begin
            if (!fseen) begin
              fseen = 1'b1;
              if (q.size() == 0 || !in_txn) begin
                chk("unexpected_flash_req", 1, 0);
              end else begin
                chk("flash_req_latency", cyc, NR + 1);
                chk("flash_on_permit", int'(q[0].deny), 0);
                chk("flash_addr", int'(u_if.flash_addr), q[0].addr);
                chk("flash_op", int'(u_if.flash_op), q[0].op);
              end
            end
            if (u_if.flash_done) done_at = cyc + 1;
          end
          if (u_if.done) begin
            if (q.size() == 0 || !in_txn) begin
              chk("unexpected_done", 1, 0);
            end else begin
              e = q.pop_front();
              chk("done_src", int'(u_if.done_src), int'(e.hw));
              chk("deny", int'(u_if.deny), int'(e.deny));
              if (e.deny) begin
                chk("deny_latency", cyc, NR + 1);
                chk("deny_no_flash", int'(fseen), 0);
              end else begin
                chk("permit_flash_seen", int'(fseen), 1);
                chk("permit_latency", cyc, done_at);
              end
            end
            in_txn = 1'b0;
          end
          if (u_if.hw_gnt || u_if.sw_gnt) begin
            chk("gnt_when_idle", int'(u_if.busy), 0);
            chk("gnt_onehot", int'(u_if.hw_gnt && u_if.sw_gnt), 0);
            if (q.size() == 0) chk("unexpected_gnt", 1, 0);
            else chk("gnt_src", int'(u_if.hw_gnt), int'(q[0].hw));
            in_txn = 1'b1;
            cyc = 0;
            fseen = 1'b0;
            done_at = -1;
          end
        end
      end
    end
  end

  task automatic start_txn(bit h, bit s, int ha, int ho, int sa, int so);
    @(posedge clk);
    #1;
    t_hw = h;
    t_sw = s;
    t_ha = ha;
    t_ho = ho;
    t_sa = sa;
    t_so = so;
    txn_id++;
  endtask

  task automatic wait_agents();
    int b;
    b = 0;
    while ((g_dut[0].agent_done != txn_id || g_dut[1].agent_done != txn_id) && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (b >= 500) chk("agents_finish", 0, 1);
  endtask

  task automatic run_txn(bit h, bit s, int ha, int ho, int sa, int so);
    start_txn(h, s, ha, ho, sa, so);
    wait_agents();
  endtask

  task automatic set_region(int r, bit en, bit rd, bit pg, bit er, int base, int size);
    cfg_v[r].en = en;
    cfg_v[r].rd_en = rd;
    cfg_v[r].prog_en = pg;
    cfg_v[r].erase_en = er;
    cfg_v[r].base = AW'(base);
    cfg_v[r].size = size[AW:0];
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_dut0"}, int'({g_dut[0].u_if.busy, g_dut[0].u_if.flash_req, g_dut[0].u_if.done,
                            g_dut[0].u_if.deny, g_dut[0].u_if.hw_gnt, g_dut[0].u_if.sw_gnt}), 0);
    chk({tag, "_dut1"}, int'({g_dut[1].u_if.busy, g_dut[1].u_if.flash_req, g_dut[1].u_if.done,
                            g_dut[1].u_if.deny, g_dut[1].u_if.hw_gnt, g_dut[1].u_if.sw_gnt}), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int b;
    repeat (3) @(negedge clk);
    chk_quiet("reset_state");
    rst_n = 1'b1;

    // Region0 allows reads only over 0x08..0x17.
    set_region(0, 1'b1, 1'b1, 1'b0, 1'b0, 'h08, 'h10);
    run_txn(1'b0, 1'b1, 0, 0, 'h10, 0);
    run_txn(1'b0, 1'b1, 0, 0, 'h10, 1);
    run_txn(1'b1, 1'b1, 'h10, 0, 'h12, 0);
    run_txn(1'b1, 1'b1, 'h14, 1, 'h12, 0);
    run_txn(1'b1, 1'b0, 'h80, 2, 0, 0);
    run_txn(1'b1, 1'b0, 'h10, 3, 0, 0);
    run_txn(1'b0, 1'b1, 0, 0, 'h10, 3);

    set_region(0, 1'b1, 1'b0, 1'b1, 1'b1, 'h00, 'h20);
    set_region(1, 1'b1, 1'b1, 1'b1, 1'b1, 'h10, 'h10);
    run_txn(1'b0, 1'b1, 0, 0, 'h18, 0);
    set_region(2, 1'b1, 1'b1, 1'b0, 1'b0, 'hF0, 'h10);
    run_txn(1'b0, 1'b1, 0, 0, 'hFF, 0);
    set_region(2, 1'b1, 1'b0, 1'b0, 1'b0, 'hF0, 'h00);
    dflt_v = '{en: 1'b1, rd_en: 1'b1, prog_en: 1'b0, erase_en: 1'b0};
    run_txn(1'b0, 1'b1, 0, 0, 'hF5, 0);
    dflt_v = '0;
    run_txn(1'b1, 1'b1, 'hF5, 0, 'hF6, 0);

    for (int i = 0; i < 60; i++) begin
      int ha, sa, hs, ss;
      if (i % 8 == 0) begin
        for (int r = 0; r < NR; r++) begin
          int sz;
          sz = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 256);
          set_region(r, 1'(($urandom_range(0, 3)) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 255), sz);
        end
        dflt_v = 4'($urandom_range(0, 15));
      end
      hs = $urandom_range(0, NR - 1);
      ss = $urandom_range(0, NR - 1);
      ha = ($urandom_range(0, 1) != 0) ? (int'(cfg_v[hs].base) + $urandom_range(0, 31)) % 256
                                       : $urandom_range(0, 255);
      sa = ($urandom_range(0, 1) != 0) ? (int'(cfg_v[ss].base) + $urandom_range(0, 31)) % 256
                                       : $urandom_range(0, 255);
      case ($urandom_range(0, 2))
        0:       run_txn(1'b1, 1'b0, ha, $urandom_range(0, 3), sa, $urandom_range(0, 3));
        1:       run_txn(1'b0, 1'b1, ha, $urandom_range(0, 3), sa, $urandom_range(0, 3));
        default: run_txn(1'b1, 1'b1, ha, $urandom_range(0, 3), sa, $urandom_range(0, 3));
      endcase
    end

    // Reset while flash is outstanding: request must drop at once and no completion follows.
    cfg_v = '0;
    dflt_v = '0;
    set_region(0, 1'b1, 1'b1, 1'b0, 1'b0, 'h08, 'h10);
    hold_flash = 1'b1;
    start_txn(1'b0, 1'b1, 0, 0, 'h10, 0);
    b = 0;
    while (!(g_dut[0].u_if.flash_req && g_dut[1].u_if.flash_req) && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("issue_before_reset", int'(g_dut[0].u_if.flash_req && g_dut[1].u_if.flash_req), 1);
    #2;
    rst_n = 1'b0;
    rst_cnt++;
    #1;
    chk_quiet("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_flash = 1'b0;
    wait_agents();
    run_txn(1'b1, 1'b1, 'h10, 0, 'h11, 0);
    run_txn(1'b0, 1'b1, 0, 0, 'h12, 0);

    repeat (5) @(negedge clk);
    chk("queue_drained_dut0", g_dut[0].q.size(), 0);
    chk("queue_drained_dut1", g_dut[1].q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
